// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: sequences a DSP48-style multiply-accumulate job and returns the P register result
module dsp_mac_seq #(
  parameter int LEN_W = 8,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             cfg_preadd,
  input  logic             cfg_presub,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_ceopmode,
  output logic             dsp_rstp,
  output logic [7:0]       dsp_opmode,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             preadd_q, preadd_d, presub_q, presub_d;
  logic [LAT-1:0]   v_q, v_d;
  logic [7:0]       opm_q, opm_d;
  logic [47:0]      res_q, res_d;
  logic             go, rdy, acc, last, cap;
  // Handshake decode; the drain capture fires when the final beat's token reaches the pipe end
  always_comb begin
    go   = state_q == IDLE && start;
    rdy  = state_q == RUN && cnt_q < len_q;
    acc  = in_valid && rdy;
    last = acc && (cnt_q + LEN_W'(1)) == len_q;
    cap  = state_q == DRAIN && v_q[LAT-1] && ~|v_q[LAT-2:0];
    v_d  = {v_q[LAT-2:0], acc};
  end
  // Next-state logic for job control, beat counting, opmode word and result capture
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    preadd_d = preadd_q;
    presub_d = presub_q;
    opm_d    = opm_q;
    res_d    = res_q;
    case (state_q)
      IDLE: if (start) begin
        len_d    = len;
        preadd_d = cfg_preadd;
        presub_d = cfg_presub;
        cnt_d    = '0;
        res_d    = '0;
        state_d  = len == '0 ? DONE : RUN;
      end
      RUN: if (acc) begin
        cnt_d   = cnt_q + LEN_W'(1);
        opm_d   = {1'b0, presub_q, 1'b0, preadd_q, cnt_q == '0 ? 2'b00 : 2'b10, 2'b01};
        state_d = last ? DRAIN : RUN;
      end
      DRAIN: if (cap) begin
        res_d   = dsp_p;
        state_d = DONE;
      end
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      preadd_q <= 1'b0;
      presub_q <= 1'b0;
      v_q      <= '0;
      opm_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      preadd_q <= preadd_d;
      presub_q <= presub_d;
      v_q      <= v_d;
      opm_q    <= opm_d;
      res_q    <= res_d;
    end
  end
  // Outputs are forced quiet while reset is asserted, even before the registers clear
  always_comb begin
    busy         = !RST && state_q != IDLE;
    in_ready     = !RST && rdy;
    dsp_cea      = !RST && acc;
    dsp_ceb      = !RST && acc;
    dsp_cem      = !RST && v_q[0];
    dsp_ceopmode = !RST && v_q[0];
    dsp_cep      = !RST && v_q[1];
    dsp_rstp     = !RST && go && len != '0;
    dsp_opmode   = RST ? 8'h00 : opm_q;
    res_valid    = !RST && state_q == DONE;
    res_data     = RST ? 48'h0 : res_q;
  end
endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: randomized and directed checks of dsp_mac_seq against a DSP model and sum-of-products reference
module tb_dsp_mac_seq;
  localparam int LAT = 3;
  logic        clk, RST, start, cfg_preadd, cfg_presub, in_valid, res_ready;
  logic [7:0]  len;
  logic        busy, in_ready, dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_rstp, res_valid;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p, res_data;
  logic [47:0] a_in, b_in, d_in, a1, b1, d1, m, p;
  logic [7:0]  opm;
  logic [47:0] opa [256];
  logic [47:0] opb [256];
  logic [47:0] opd [256];
  int n_chk = 0, n_fail = 0;

  dsp_mac_seq #(.LEN_W(8), .LAT(LAT)) dut (
    .clk(clk), .RST(RST), .start(start), .len(len), .cfg_preadd(cfg_preadd), .cfg_presub(cfg_presub),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb),
    .dsp_cem(dsp_cem), .dsp_cep(dsp_cep), .dsp_ceopmode(dsp_ceopmode), .dsp_rstp(dsp_rstp),
    .dsp_opmode(dsp_opmode), .dsp_p(dsp_p), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Behavioural DSP slice: A1/B1/D regs, pre-adder + multiplier into M, opmode reg, P accumulator
  always @(posedge clk) begin
    if (dsp_cea) a1 <= a_in;
    if (dsp_ceb) begin b1 <= b_in; d1 <= d_in; end
    if (dsp_cem) m <= (dsp_opmode[4] ? (dsp_opmode[6] ? d1 - b1 : d1 + b1) : b1) * a1;
    if (dsp_ceopmode) opm <= dsp_opmode;
    if (dsp_rstp) p <= '0;
    else if (dsp_cep) p <= (opm[3:2] == 2'b10 ? p : 48'h0) + m;
  end
  assign dsp_p = p;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] prod(logic [47:0] a, logic [47:0] b, logic [47:0] d, bit pa, bit ps);
    return (pa ? (ps ? d - b : d + b) : b) * a;
  endfunction

  task automatic do_reset();
    RST = 1; start = 0; in_valid = 0; res_ready = 0;
    #1;
    chk("rst_outs", {busy, in_ready, dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_rstp, dsp_opmode, res_valid}, 0);
    @(posedge clk); #1;
    chk("rst_outs_q", {busy, in_ready, dsp_cem, dsp_cep, dsp_opmode, res_valid, res_data}, 0);
    RST = 0; #1;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      opa[i] = 48'($urandom_range(0, 262143));
      opb[i] = 48'($urandom_range(0, 262143));
      opd[i] = 48'($urandom_range(0, 262143));
    end
  endtask

  // gapm: 0 = continuous, 1 = two idle cycles after beat 2, 2 = random gaps
  task automatic run_job(input int n, input bit pa, input bit ps, input int gapm, input int hold);
    logic [47:0] exp = '0;
    int k = 0, g = 0, n_cep = 0, n_cea = 0, t_rv = -1, t_first = -1, t_last = -1;
    bit prev_acc = 0, prev_first = 0;
    start = 1; len = 8'(n); cfg_preadd = pa; cfg_presub = ps; in_valid = 0;
    #1;
    chk("start_rstp", dsp_rstp, n != 0);
    chk("start_cea", dsp_cea, 0);
    @(posedge clk); #1;
    start = 0;
    for (int cyc = 1; cyc < 4 * n + 60 && t_rv < 0; cyc++) begin
      in_valid = (k < n) && !(gapm == 1 && k == 2 && g < 2) && (gapm != 2 || $urandom_range(0, 2) != 0);
      if (gapm == 1 && k == 2 && g < 2) g++;
      a_in = opa[k]; b_in = opb[k]; d_in = opd[k];
      #1;
      if (res_valid) t_rv = cyc;
      else chk("in_ready", in_ready, k < n);
      if (dsp_cep) n_cep++;
      if (dsp_cea) n_cea++;
      if (prev_acc) begin
        chk("opmode", dsp_opmode, {1'b0, ps, 1'b0, pa, prev_first ? 2'b00 : 2'b10, 2'b01});
        chk("cem", {dsp_cem, dsp_ceopmode}, 2'b11);
      end
      prev_acc = in_valid && in_ready;
      prev_first = k == 0;
      if (prev_acc) begin
        exp += prod(opa[k], opb[k], opd[k], pa, ps);
        if (k == 0) t_first = cyc;
        t_last = cyc;
        k++;
      end
      if (t_rv < 0) begin @(posedge clk); #1; end
    end
    in_valid = 0;
    chk("res_valid_seen", t_rv >= 0, 1);
    if (t_rv < 0) begin do_reset(); return; end
    chk("res_data", res_data, exp);
    chk("cep_count", n_cep, n);
    chk("cea_count", n_cea, n);
    chk("latency", n == 0 ? t_rv : t_rv - t_last, n == 0 ? 1 : LAT + 1);
    if (gapm == 0 && n > 0) chk("first_to_valid", t_rv - t_first, n + LAT);
    for (int i = 0; i <= hold; i++) begin
      res_ready = (i == hold); start = 1; len = 8'd3;
      #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, exp);
      chk("hold_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    start = 0; res_ready = 0;
    #1;
    chk("idle_after", {busy, res_valid}, 0);
  endtask

  initial begin
    start = 0; len = 0; cfg_preadd = 0; cfg_presub = 0; in_valid = 0; res_ready = 0;
    a_in = 0; b_in = 0; d_in = 0;
    do_reset();
    opa[0] = 1; opa[1] = 2; opa[2] = 3; opa[3] = 4;
    opb[0] = 5; opb[1] = 6; opb[2] = 7; opb[3] = 8;
    opd[0] = 0; opd[1] = 0; opd[2] = 0; opd[3] = 0;
    run_job(4, 0, 0, 0, 0);
    run_job(4, 0, 0, 1, 0);
    opa[0] = 2; opb[0] = 3; opd[0] = 10;
    run_job(1, 1, 1, 0, 0);
    run_job(0, 0, 0, 0, 0);
    fill_rand(6);
    run_job(6, 0, 0, 2, 5);
    start = 1; len = 8'd4; cfg_preadd = 0; cfg_presub = 0;
    @(posedge clk); #1;
    start = 0; in_valid = 1;
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 0; #1;
    chk("drain_busy", {busy, in_ready}, 2'b10);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_abort", {busy, res_valid}, 0);
    end
    opa[0] = 2; opb[0] = 2; opd[0] = 0;
    run_job(1, 0, 0, 0, 0);
    for (int j = 0; j < 8; j++) begin
      int n = $urandom_range(1, 12);
      fill_rand(n);
      run_job(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, $urandom_range(0, 3));
    end
    fill_rand(255);
    run_job(255, 1, 0, 2, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Parameters
REQ-001 SHALL provide parameter LEN_W, default 8: width of the beat-count port len.
REQ-002 SHALL provide parameter LAT, default 3: cycles from an accepted beat to its product landing in the DSP P register (A1REG=1, B1REG=1, MREG=1, PREG=1); LAT SHALL be at least 2.

Interface
REQ-003 SHALL have the following ports:
- clk  in  1  single clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request a new accumulation; honoured only in IDLE.
- len  in  LEN_W  number of operand beats; sampled when start is honoured.
- cfg_preadd  in  1  use pre-adder (D±B); sampled with start.
- cfg_presub  in  1  pre-adder subtracts (D-B) when 1; sampled with start.
- busy  out  1  high in any state other than IDLE.
- in_valid  in  1  upstream presents A/B/D operands to the DSP this cycle.
- in_ready  out  1  controller accepts a beat this cycle.
- dsp_cea, dsp_ceb  out  1 each  A/B register enables.
- dsp_cem  out  1  M register enable.
- dsp_cep  out  1  P register enable.
- dsp_ceopmode  out  1  opmode register enable.
- dsp_rstp  out  1  P register reset pulse.
- dsp_opmode  out  8  opmode word to the DSP.
- dsp_p  in  48  DSP P output.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_data  out  48  accumulated result.

Function
REQ-004 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-005 IDLE: on start, SHALL latch len, cfg_preadd and cfg_presub, clear the beat counter, pulse dsp_rstp for one cycle, and go to RUN; if len==0 it SHALL go to DONE instead, with res_data=0 and no DSP enables asserted.
REQ-006 SHALL drive in_ready = (state==RUN) && (accepted beats < latched len).
REQ-007 SHALL define a beat as accepted in cycle t when in_valid && in_ready.
REQ-008 SHALL drive dsp_cea = dsp_ceb = beat accepted (combinational).
REQ-009 SHALL assert dsp_ceopmode in cycle t+1 for each beat accepted in cycle t.
REQ-010 SHALL present dsp_opmode in cycle t+1 as {1'b0, cfg_presub, 1'b0, cfg_preadd, Z[1:0], X[1:0]}, with X=2'b01 (M) and Z=2'b00 for the first beat of a job and Z=2'b10 (P) for every later beat.
REQ-011 SHALL assert dsp_cem in cycle t+1 and dsp_cep in cycle t+2 for each beat accepted in cycle t.
REQ-012 SHALL track beats with a LAT-deep valid shift pipeline; gaps in in_valid SHALL insert bubbles, and enables SHALL stay low for bubbles so P holds its value.
REQ-013 SHALL leave dsp_opmode at its last value when no beat is in flight.
REQ-014 SHALL go from RUN to DRAIN in the cycle after the final beat is accepted.
REQ-015 DRAIN: SHALL wait until the valid pipeline is empty, capture dsp_p into res_data at cycle t_last+LAT, then enter DONE, giving res_valid=1 at t_last+LAT+1.
REQ-016 DONE: SHALL hold res_valid and res_data stable until res_ready=1, then return to IDLE in the next cycle.
REQ-017 SHALL ignore start when the state is not IDLE, including a start coinciding with the res_ready handshake in DONE.
REQ-018 SHALL treat the beat counter as LEN_W bits; len = 2^LEN_W-1 SHALL complete with no wrap-around.
REQ-019 SHALL perform no arithmetic itself; the result is exactly the DSP P value, 48 bits, with wrap-around in the DSP.

Reset
REQ-020 RST SHALL force state IDLE and clear the counter, valid pipeline and res_data.
REQ-021 While RST is high, all outputs SHALL be 0: busy, in_ready, all dsp_ce*, dsp_rstp, dsp_opmode=8'h00, res_valid.
REQ-022 RST mid-job SHALL abort the job with no res_valid; the next start SHALL begin a fresh job with Z=0 on its first beat.

Verification
REQ-023 Directed scenario: len=4; A={1,2,3,4}, B={5,6,7,8}; in_valid held high -> in_ready high for 4 cycles, res_valid 7 cycles after the first beat, res_data=70.
REQ-024 Directed scenario: same job with in_valid low for 2 cycles after beat 2 -> res_data=70, dsp_cep asserted exactly 4 times.
REQ-025 Directed scenario: cfg_preadd=1, cfg_presub=1, len=1, D=10, B=3, A=2 -> dsp_opmode=8'h51, res_data=14.
REQ-026 Directed scenario: len=0 -> res_valid the cycle after start, res_data=0, no dsp_ce* pulses.
REQ-027 Directed scenario: res_ready held low for 5 cycles -> res_valid and res_data stable; start pulses ignored; in_ready=0.
REQ-028 Directed scenario: RST during DRAIN -> IDLE next cycle with all outputs 0; a following job with len=1, A=B=2 -> res_data=4.
